// File: rtl/wb_stage_pkg.sv
// Shared pipeline encodings used by the writeback stage and its helpers.
package wb_stage_pkg;

    // Default datapath width for the RV32I pipeline
    localparam int DEFAULT_XLEN = 32;

    // Final-result source select carried down the pipeline
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } res_src_e;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Byte/halfword lane select and sign/zero extension of a raw memory word.
// Purely combinational so the misaligned-access unit can reuse it.
module load_ext
    import wb_stage_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane and halfword lane of the low 32 bits
    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane; unknown sizes pass the raw word through
    always_comb begin
        ext = word;
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   ext = word;
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB boundary register with stall/flush, load
// extension, final result select, register-file write port and the
// retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic [XLEN-1:0]  ImmExtM,
    input  logic [4:0]       RdM,
    output logic             ValidW,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] InstRetW
);

    logic             valid_q;
    logic             reg_write_q;
    res_src_e         result_src_q;
    logic [2:0]       funct3_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  pc4_q;
    logic [XLEN-1:0]  imm_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  load_data;
    logic             retire;

    // The W instruction leaves the stage unless it is held by a stall
    assign retire = valid_q && (!StallW || FlushW);

    // MEM/WB register: flush inserts a bubble, stall holds, else capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= RES_ALU;
            funct3_q     <= 3'b000;
            alu_q        <= '0;
            rdata_q      <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            rd_q         <= 5'd0;
        end else if (FlushW) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= RES_ALU;
            funct3_q     <= 3'b000;
            alu_q        <= '0;
            rdata_q      <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            rd_q         <= 5'd0;
        end else if (!StallW) begin
            valid_q      <= ValidM;
            reg_write_q  <= RegWriteM;
            result_src_q <= res_src_e'(ResultSrcM);
            funct3_q     <= Funct3M;
            alu_q        <= ALUResultM;
            rdata_q      <= ReadDataM;
            pc4_q        <= PCPlus4M;
            imm_q        <= ImmExtM;
            rd_q         <= RdM;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .word  (rdata_q),
        .addr  (alu_q[1:0]),
        .funct3(funct3_q),
        .ext   (load_data)
    );

    // Final result select from the registered source field
    always_comb begin
        ResultW = alu_q;
        case (result_src_q)
            RES_ALU: ResultW = alu_q;
            RES_MEM: ResultW = load_data;
            RES_PC4: ResultW = pc4_q;
            RES_IMM: ResultW = imm_q;
            default: ResultW = alu_q;
        endcase
    end

    // Register-file write is suppressed for bubbles and for x0
    assign RegWriteW = reg_write_q && valid_q && (rd_q != 5'd0);
    assign ValidW    = valid_q;
    assign RdW       = rd_q;
    assign InstRetW  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for the writeback stage.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        StallW;
    logic        FlushW;
    logic        ValidM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] ReadDataM;
    logic [31:0] PCPlus4M;
    logic [31:0] ImmExtM;
    logic [4:0]  RdM;
    logic        ValidW;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [63:0] InstRetW;

    int          total;
    int          bad;
    logic [63:0] exp_cnt;
    logic        exp_valid;
    logic [63:0] held_cnt;

    wb_stage #(
        .XLEN (32),
        .CNT_W(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .StallW    (StallW),
        .FlushW    (FlushW),
        .ValidM    (ValidM),
        .RegWriteM (RegWriteM),
        .ResultSrcM(ResultSrcM),
        .Funct3M   (Funct3M),
        .ALUResultM(ALUResultM),
        .ReadDataM (ReadDataM),
        .PCPlus4M  (PCPlus4M),
        .ImmExtM   (ImmExtM),
        .RdM       (RdM),
        .ValidW    (ValidW),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .InstRetW  (InstRetW)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] src,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [31:0] pc4,
                                 input logic [31:0] imm, input logic [4:0] rd);
        ValidM     = v;
        RegWriteM  = rw;
        ResultSrcM = src;
        Funct3M    = f3;
        ALUResultM = alu;
        ReadDataM  = rdata;
        PCPlus4M   = pc4;
        ImmExtM    = imm;
        RdM        = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the expected retire count follows the leave-the-stage rule
    task automatic tick();
        bit leaves;
        leaves = exp_valid && (!StallW || FlushW);
        @(posedge clk);
        if (leaves) exp_cnt = exp_cnt + 64'd1;
        exp_valid = FlushW ? 1'b0 : (StallW ? exp_valid : ValidM);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_cnt   = 64'd0;
        exp_valid = 1'b0;
        reset     = 1'b0;
        StallW    = 1'b0;
        FlushW    = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_valid", {63'd0, ValidW}, 64'd0);
        checkOutput("rst_regwrite", {63'd0, RegWriteW}, 64'd0);
        checkOutput("rst_rd", {59'd0, RdW}, 64'd0);
        checkOutput("rst_result", {32'd0, ResultW}, 64'd0);
        checkOutput("rst_instret", InstRetW, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // First capture after release
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b010, 32'h11, 32'h5555_5555, 32'h204, 32'h7000, 5'd3);
        tick();
        checkOutput("cap_valid", {63'd0, ValidW}, 64'd1);
        checkOutput("cap_result", {32'd0, ResultW}, 64'h11);
        checkOutput("cap_rd", {59'd0, RdW}, 64'd3);
        checkOutput("cap_regwrite", {63'd0, RegWriteW}, 64'd1);
        checkOutput("cap_instret", InstRetW, 64'd0);
        tick();
        checkOutput("cap_instret2", InstRetW, 64'd1);

        // Asynchronous reset mid-cycle with nonzero inputs
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", {63'd0, ValidW}, 64'd0);
        checkOutput("midrst_regwrite", {63'd0, RegWriteW}, 64'd0);
        checkOutput("midrst_result", {32'd0, ResultW}, 64'd0);
        checkOutput("midrst_rd", {59'd0, RdW}, 64'd0);
        checkOutput("midrst_instret", InstRetW, 64'd0);
        @(negedge clk);
        reset     = 1'b1;
        exp_cnt   = 64'd0;
        exp_valid = 1'b0;
        tick();
        checkOutput("postrst_valid", {63'd0, ValidW}, 64'd1);
        checkOutput("postrst_result", {32'd0, ResultW}, 64'h11);
        checkOutput("postrst_instret", InstRetW, 64'd0);

        // Load extension
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LB, 32'h1001, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lb_a1", {32'd0, ResultW}, 64'hFFFF_FFAA);
        checkOutput("lb_instret", InstRetW, 64'd1);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LBU, 32'h1001, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lbu_a1", {32'd0, ResultW}, 64'h0000_00AA);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LB, 32'h1003, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lb_a3", {32'd0, ResultW}, 64'hFFFF_FF88);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LBU, 32'h1000, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lbu_a0", {32'd0, ResultW}, 64'h0000_00BB);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LH, 32'h1002, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lh_a2", {32'd0, ResultW}, 64'hFFFF_8899);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LHU, 32'h1002, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lhu_a2", {32'd0, ResultW}, 64'h0000_8899);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LH, 32'h1001, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lh_a1", {32'd0, ResultW}, 64'hFFFF_AABB);
        applyStimulus(1'b1, 1'b1, 2'b01, F3_LW, 32'h1000, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("lw", {32'd0, ResultW}, 64'h8899_AABB);
        applyStimulus(1'b1, 1'b1, 2'b01, 3'b011, 32'h1001, 32'h8899_AABB, 32'h0, 32'h0, 5'd4);
        tick();
        checkOutput("raw_f3_011", {32'd0, ResultW}, 64'h8899_AABB);
        checkOutput("load_instret", InstRetW, 64'd9);

        // Result mux and x0 suppression
        applyStimulus(1'b1, 1'b1, 2'b10, 3'b000, 32'hDEAD, 32'h0, 32'h104, 32'h0, 5'd1);
        tick();
        checkOutput("mux_pc4", {32'd0, ResultW}, 64'h104);
        applyStimulus(1'b1, 1'b1, 2'b11, 3'b000, 32'hDEAD, 32'h0, 32'h104, 32'h1234_5000, 5'd2);
        tick();
        checkOutput("mux_imm", {32'd0, ResultW}, 64'h1234_5000);
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("x0_regwrite", {63'd0, RegWriteW}, 64'd0);
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 5'd5);
        tick();
        checkOutput("rd5_regwrite", {63'd0, RegWriteW}, 64'd1);
        checkOutput("rd5_rd", {59'd0, RdW}, 64'd5);
        applyStimulus(1'b0, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 5'd6);
        tick();
        checkOutput("bubble_regwrite", {63'd0, RegWriteW}, 64'd0);
        checkOutput("bubble_valid", {63'd0, ValidW}, 64'd0);
        checkOutput("mux_instret", InstRetW, exp_cnt);

        // Stall holds the W instruction for three cycles
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b000, 32'hAAA, 32'h0, 32'h0, 32'h0, 5'd7);
        tick();
        held_cnt = InstRetW;
        StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 3'b000, 32'hC00 + i, 32'h0, 32'h0, 32'h0, 5'd9 + 5'(i));
            tick();
            checkOutput("stall_result", {32'd0, ResultW}, 64'hAAA);
            checkOutput("stall_rd", {59'd0, RdW}, 64'd7);
            checkOutput("stall_instret", InstRetW, held_cnt);
        end
        StallW = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b000, 32'hBBB, 32'h0, 32'h0, 32'h0, 5'd8);
        tick();
        checkOutput("unstall_result", {32'd0, ResultW}, 64'hBBB);
        checkOutput("unstall_instret", InstRetW, held_cnt + 64'd1);

        // Flush beats stall; the held instruction is counted once
        StallW = 1'b1;
        FlushW = 1'b1;
        tick();
        checkOutput("flush_valid", {63'd0, ValidW}, 64'd0);
        checkOutput("flush_regwrite", {63'd0, RegWriteW}, 64'd0);
        checkOutput("flush_result", {32'd0, ResultW}, 64'd0);
        checkOutput("flush_instret", InstRetW, held_cnt + 64'd2);
        StallW = 1'b0;
        FlushW = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("postflush_instret", InstRetW, held_cnt + 64'd2);

        // Ten valid instructions with one bubble in the middle
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset     = 1'b1;
        exp_cnt   = 64'd0;
        exp_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus((i != 5), 1'b1, 2'b00, 3'b000, 32'(i), 32'h0, 32'h0, 32'h0, 5'd10);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        checkOutput("ten_instret", InstRetW, 64'd10);

        // Counter wrap from all-ones
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0, 5'd11);
        tick();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        checkOutput("preload_instret", InstRetW, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        checkOutput("wrap_instret", InstRetW, 64'd0);
        checkOutput("wrap_model", InstRetW, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
